// File: rtl/video_pattern_gen.sv
// Pattern source for the packed video bus: HDMI timing with bars, ramp, checker or box content.
// Define PATGEN_CROSSHAIR_EN to add a red crosshair overlay with cross_x/cross_y inputs.

module hdmi_pack #(
  parameter int XW = 11,
  parameter int YW = 10
) (
  input  logic                  clk,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  de,
  input  logic [7:0]            r,
  input  logic [7:0]            g,
  input  logic [7:0]            b,
  input  logic [XW-1:0]         x,
  input  logic [YW-1:0]         y,
  output logic [28+XW+YW-1:0]   pack
);
  assign pack = {clk, hsync, vsync, de, r, g, b, x, y};
endmodule

module video_pattern_gen #(
  parameter int H_ACT    = 1280,
  parameter int V_ACT    = 720,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int BOX_SIZE = 64,
  parameter int BOX_STEP = 4,
  localparam int XW        = $clog2(H_ACT),
  localparam int YW        = $clog2(V_ACT),
  localparam int PACK_SIZE = 3*8+4+XW+YW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
`ifdef PATGEN_CROSSHAIR_EN
  input  logic [XW-1:0]        cross_x,
  input  logic [YW-1:0]        cross_y,
`endif
  output logic [PACK_SIZE-1:0] o_pack,
  output logic                 frame_start
);

  localparam int HT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACT + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] HA  = 12'(H_ACT);
  localparam logic [11:0] VA  = 12'(V_ACT);
  localparam logic [11:0] HS0 = 12'(H_ACT + H_FP);
  localparam logic [11:0] HS1 = 12'(H_ACT + H_FP + H_SYNC);
  localparam logic [11:0] VS0 = 12'(V_ACT + V_FP);
  localparam logic [11:0] VS1 = 12'(V_ACT + V_FP + V_SYNC);
  localparam logic [11:0] HL  = 12'(HT - 1);
  localparam logic [11:0] VL  = 12'(VT - 1);

  localparam logic [12:0] BXL = 13'(H_ACT);
  localparam logic [12:0] BYL = 13'(V_ACT);
  localparam logic [12:0] BS  = 13'(BOX_SIZE);
  localparam logic [12:0] ST  = 13'(BOX_STEP);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  state_t      state;
  logic [11:0] hcnt;
  logic [11:0] vcnt;
  logic [1:0]  mode_q;
  logic [12:0] bx;
  logic [12:0] by;
  logic        dx;
  logic        dy;

  logic        run;
  logic        h_last;
  logic        v_last;
  logic        f_last;
  logic        f_first;
  logic        de_c;
  logic        hs_c;
  logic        vs_c;
  logic [1:0]  mode_e;
  logic [2:0]  bar;
  logic        in_box;
  logic [2:0]  mask;
  logic [7:0]  lvl;
  logic [7:0]  r_c;
  logic [7:0]  g_c;
  logic [7:0]  b_c;
  logic [12:0] nbx;
  logic [12:0] nby;
  logic        ndx;
  logic        ndy;

  logic          hs_q;
  logic          vs_q;
  logic          de_q;
  logic [7:0]    r_q;
  logic [7:0]    g_q;
  logic [7:0]    b_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          fs_q;

  assign run     = state != IDLE;
  assign h_last  = hcnt == HL;
  assign v_last  = vcnt == VL;
  assign f_last  = h_last && v_last;
  assign f_first = run && hcnt == '0 && vcnt == '0;

  assign de_c = (hcnt < HA) && (vcnt < VA);
  assign hs_c = (hcnt >= HS0) && (hcnt < HS1);
  assign vs_c = (vcnt >= VS0) && (vcnt < VS1);

  assign mode_e = f_first ? mode : mode_q;

  assign in_box = ({1'b0, hcnt} >= bx) &&
                  ({1'b0, hcnt} < bx + BS) &&
                  ({1'b0, vcnt} >= by) &&
                  ({1'b0, vcnt} < by + BS);

`ifdef PATGEN_CROSSHAIR_EN
  logic [XW-1:0] cx_q;
  logic [YW-1:0] cy_q;
  logic [XW-1:0] cx_e;
  logic [YW-1:0] cy_e;

  assign cx_e = f_first ? cross_x : cx_q;
  assign cy_e = f_first ? cross_y : cy_q;

  // Crosshair position latched once per frame
  always_ff @(posedge clk) begin
    if (rst) begin
      cx_q <= '0;
      cy_q <= '0;
    end else if (f_first) begin
      cx_q <= cross_x;
      cy_q <= cross_y;
    end
  end
`endif

  // Bar index: largest k whose threshold the pixel has reached
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++)
      if (int'(hcnt) >= k * H_ACT / 8)
        bar = 3'(k);
  end

  // Pixel colour as a channel mask plus a common level
  always_comb begin
    mask = 3'b000;
    lvl  = 8'hFF;
    unique case (mode_e)
      2'd0: begin
        unique case (bar)
          3'd0: mask = 3'b111;
          3'd1: mask = 3'b110;
          3'd2: mask = 3'b011;
          3'd3: mask = 3'b010;
          3'd4: mask = 3'b101;
          3'd5: mask = 3'b100;
          3'd6: mask = 3'b001;
          3'd7: mask = 3'b000;
        endcase
      end
      2'd1: begin
        mask = 3'b111;
        lvl  = hcnt[7:0];
      end
      2'd2: mask = {3{hcnt[5] ^ vcnt[5]}};
      2'd3: mask = {3{in_box}};
    endcase
`ifdef PATGEN_CROSSHAIR_EN
    if (hcnt == 12'(cx_e) || vcnt == 12'(cy_e)) begin
      mask = 3'b100;
      lvl  = 8'hFF;
    end
`endif
    r_c = (de_c && mask[2]) ? lvl : 8'h00;
    g_c = (de_c && mask[1]) ? lvl : 8'h00;
    b_c = (de_c && mask[0]) ? lvl : 8'h00;
  end

  // Next box position; stays put on an axis too short to move
  always_comb begin
    nbx = bx;
    ndx = dx;
    nby = by;
    ndy = dy;
    if (dx) begin
      if (bx + BS + ST > BXL) begin
        ndx = 1'b0;
        nbx = (bx >= ST) ? bx - ST : bx;
      end else begin
        nbx = bx + ST;
      end
    end else begin
      if (bx < ST) begin
        ndx = 1'b1;
        nbx = (bx + BS + ST <= BXL) ? bx + ST : bx;
      end else begin
        nbx = bx - ST;
      end
    end
    if (dy) begin
      if (by + BS + ST > BYL) begin
        ndy = 1'b0;
        nby = (by >= ST) ? by - ST : by;
      end else begin
        nby = by + ST;
      end
    end else begin
      if (by < ST) begin
        ndy = 1'b1;
        nby = (by + BS + ST <= BYL) ? by + ST : by;
      end else begin
        nby = by - ST;
      end
    end
  end

  // Run/stop FSM and raster counters; a stop always finishes the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hcnt  <= '0;
      vcnt  <= '0;
    end else begin
      if (run) begin
        if (h_last) begin
          hcnt <= '0;
          vcnt <= v_last ? '0 : vcnt + 12'd1;
        end else begin
          hcnt <= hcnt + 12'd1;
        end
      end
      unique case (state)
        IDLE: if (en) state <= RUN;
        RUN:  if (!en) state <= f_last ? IDLE : STOP;
        STOP: if (f_last) state <= en ? RUN : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pattern select held for a whole frame
  always_ff @(posedge clk) begin
    if (rst)
      mode_q <= 2'd0;
    else if (f_first)
      mode_q <= mode;
  end

  // Box moves once per frame on the last raster cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      bx <= '0;
      by <= '0;
      dx <= 1'b1;
      dy <= 1'b1;
    end else if (run && f_last) begin
      bx <= nbx;
      by <= nby;
      dx <= ndx;
      dy <= ndy;
    end
  end

  // Registered pack fields, zero while idle
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      de_q <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      x_q  <= '0;
      y_q  <= '0;
      fs_q <= 1'b0;
    end else begin
      hs_q <= hs_c;
      vs_q <= vs_c;
      de_q <= de_c;
      r_q  <= r_c;
      g_q  <= g_c;
      b_q  <= b_c;
      x_q  <= de_c ? hcnt[XW-1:0] : '0;
      y_q  <= de_c ? vcnt[YW-1:0] : '0;
      fs_q <= f_first;
    end
  end

  assign frame_start = fs_q;

  hdmi_pack #(
    .XW(XW),
    .YW(YW)
  ) u_pack (
    .clk  (clk),
    .hsync(hs_q),
    .vsync(vs_q),
    .de   (de_q),
    .r    (r_q),
    .g    (g_q),
    .b    (b_q),
    .x    (x_q),
    .y    (y_q),
    .pack (o_pack)
  );

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a 16x4 raster (22x7 total).
// Samples on the falling edge; k indexes pack samples from the first frame_start.

module tb_video_pattern_gen;

  localparam int HT = 22;
  localparam int VT = 7;
  localparam int FT = HT * VT;
  localparam int PS = 34;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [PS-1:0] o_pack;
  logic          frame_start;

  logic [1:0]  y_o;
  logic [3:0]  x_o;
  logic [23:0] rgb_o;
  logic        de_o;
  logic        vs_o;
  logic        hs_o;

  int checks = 0;
  int errors = 0;
  int k = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
                            24'h00FF00, 24'hFF00FF, 24'hFF0000,
                            24'h0000FF, 24'h000000};

  assign y_o   = o_pack[1:0];
  assign x_o   = o_pack[5:2];
  assign rgb_o = o_pack[29:6];
  assign de_o  = o_pack[30];
  assign vs_o  = o_pack[31];
  assign hs_o  = o_pack[32];

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACT(16), .V_ACT(4),
    .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_FP(1), .V_SYNC(1), .V_BP(1),
    .BOX_SIZE(4), .BOX_STEP(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .o_pack     (o_pack),
    .frame_start(frame_start)
  );

  function automatic int eh(int s);
    return s % HT;
  endfunction

  function automatic int ev(int s);
    return (s / HT) % VT;
  endfunction

  function automatic logic exp_de(int s);
    return eh(s) < 16 && ev(s) < 4;
  endfunction

  function automatic logic [9:0] exp_tim(int s);
    logic d;
    logic [3:0] x;
    logic [1:0] y;
    d = exp_de(s);
    x = d ? 4'(eh(s)) : 4'd0;
    y = d ? 2'(ev(s)) : 2'd0;
    return {d, eh(s) >= 18 && eh(s) < 20, ev(s) == 5,
            eh(s) == 0 && ev(s) == 0, x, y};
  endfunction

  task automatic tick();
    @(negedge clk);
    k++;
  endtask

  task automatic restart(input logic [1:0] m);
    rst = 1'b1;
    en = 1'b0;
    mode = m;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    k = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_pack[32:0] !== 33'd0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pack=%h fs=%b want 0/0", o_pack, frame_start);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (o_pack[32:0] !== 33'd0 || frame_start !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold pack=%h fs=%b want 0/0", o_pack, frame_start);
      end
    end
  endtask

  task automatic test_timing();
    rst = 1'b1;
    en = 1'b0;
    mode = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b0 || o_pack[32:0] !== 33'd0) begin
      errors++;
      $display("FAIL first_run_cycle fs=%b pack=%h want 0/0", frame_start, o_pack);
    end
    @(negedge clk);
    k = 0;
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL first_frame_start fs=%b want 1", frame_start);
    end
    for (int i = 0; i < 2 * FT; i++) begin
      checks++;
      if ({de_o, hs_o, vs_o, frame_start, x_o, y_o} !== exp_tim(k)) begin
        errors++;
        $display("FAIL timing k=%0d got %b want %b", k,
                 {de_o, hs_o, vs_o, frame_start, x_o, y_o}, exp_tim(k));
      end
      tick();
    end
  endtask

  task automatic test_colour_bars();
    logic [23:0] want;
    restart(2'd0);
    for (int i = 0; i < FT; i++) begin
      want = exp_de(k) ? bars[eh(k) / 2] : 24'h0;
      checks++;
      if (rgb_o !== want) begin
        errors++;
        $display("FAIL bars k=%0d rgb=%h want %h", k, rgb_o, want);
      end
      tick();
    end
  endtask

  task automatic test_mode_change();
    logic [24:0] want;
    restart(2'd0);
    while (k < HT + 5) tick();
    mode = 2'd2;
    while (k < 2 * FT) begin
      if (k < FT)
        want = {exp_de(k), exp_de(k) ? bars[eh(k) / 2] : 24'h0};
      else
        want = {exp_de(k), 24'h0};
      checks++;
      if ({de_o, rgb_o} !== want) begin
        errors++;
        $display("FAIL mode_change k=%0d got %h want %h", k, {de_o, rgb_o}, want);
      end
      tick();
    end
  endtask

  task automatic test_box_bounce();
    int bxs [9] = '{0, 2, 4, 6, 8, 10, 12, 10, 8};
    logic [23:0] want;
    restart(2'd3);
    for (int f = 0; f < 9; f++) begin
      for (int i = 0; i < FT; i++) begin
        want = (exp_de(k) && eh(k) >= bxs[f] && eh(k) < bxs[f] + 4) ?
               24'hFFFFFF : 24'h0;
        checks++;
        if (rgb_o !== want) begin
          errors++;
          $display("FAIL box f=%0d k=%0d rgb=%h want %h", f, k, rgb_o, want);
        end
        tick();
      end
    end
  endtask

  task automatic test_stop();
    restart(2'd0);
    while (k < 2 * FT + HT + 3) tick();
    en = 1'b0;
    while (k < 3 * FT) begin
      checks++;
      if ({de_o, hs_o, vs_o, frame_start, x_o, y_o} !== exp_tim(k)) begin
        errors++;
        $display("FAIL stop_drain k=%0d got %b want %b", k,
                 {de_o, hs_o, vs_o, frame_start, x_o, y_o}, exp_tim(k));
      end
      tick();
    end
    for (int i = 0; i < FT + 10; i++) begin
      checks++;
      if (o_pack[32:0] !== 33'd0 || frame_start !== 1'b0) begin
        errors++;
        $display("FAIL stop_idle i=%0d pack=%h fs=%b want 0/0", i, o_pack, frame_start);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    restart(2'd0);
    while (k < 2 * FT + HT + 3) tick();
    en = 1'b0;
    while (k < 4 * FT) begin
      checks++;
      if ({de_o, hs_o, vs_o, frame_start, x_o, y_o} !== exp_tim(k)) begin
        errors++;
        $display("FAIL no_gap k=%0d got %b want %b", k,
                 {de_o, hs_o, vs_o, frame_start, x_o, y_o}, exp_tim(k));
      end
      if (k == 3 * FT - 2) en = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [24:0] want;
    restart(2'd3);
    while (k < FT) tick();
    for (int i = 0; i < 6; i++) begin
      want = {1'b1, (i >= 2) ? 24'hFFFFFF : 24'h0};
      checks++;
      if ({de_o, rgb_o} !== want) begin
        errors++;
        $display("FAIL box_moved x=%0d got %h want %h", i, {de_o, rgb_o}, want);
      end
      tick();
    end
    while (k < FT + 2 * HT + 10) tick();
    rst = 1'b1;
    en = 1'b0;
    tick();
    checks++;
    if (o_pack[32:0] !== 33'd0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid pack=%h fs=%b want 0/0", o_pack, frame_start);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (o_pack[32:0] !== 33'd0) begin
        errors++;
        $display("FAIL reset_mid_idle pack=%h want 0", o_pack);
      end
    end
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    k = 0;
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL restart_fs fs=%b want 1", frame_start);
    end
    for (int i = 0; i < 16; i++) begin
      want = {1'b1, (i < 4) ? 24'hFFFFFF : 24'h0};
      checks++;
      if ({de_o, rgb_o} !== want) begin
        errors++;
        $display("FAIL box_home x=%0d got %h want %h", i, {de_o, rgb_o}, want);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_colour_bars();
    test_mode_change();
    test_box_bounce();
    test_stop();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
